reg_index_encoder: RTL and testbench
====================================

// Module: reg_index_encoder
// PURPOSE
//  Inverse of the register-index decoder. Accepts a 16-bit register write-enable mask
//  (one-hot, or multi-hot) plus a 5-bit 1-based mux select, and returns 4-bit register indices.
//  Multi-hot masks are serialised lowest-index-first over a valid/ready handshake.
//  Sits between the register-file write-enable bus and the trace/hazard logic that needs 4-bit indices.
// PARAMETERS
//  NREG   16  number of registers; equals the mask width
//  IDXW   4   index width; must equal clog2(NREG)
// PORTS
//  clk          in   1     system clock, rising edge
//  reset        in   1     asynchronous, active-high reset
//  req_valid    in   1     mask request is presented
//  req_ready    out  1     block can accept a mask (IDLE state)
//  req_mask     in   16    write-enable mask; bit n selects register rn
//  sel_in       in   5     1-based mux select; 1..16 = r0..r15, 0 = none
//  sel_idx      out  4     registered value of sel_in-1
//  sel_err      out  1     registered; high when sel_in==0 or sel_in>16
//  idx_valid    out  1     idx_out holds a pending index
//  idx_ready    in   1     consumer accepts idx_out
//  idx_out      out  4     lowest pending register index
//  idx_last     out  1     idx_out is the final index of the current mask
//  err_empty    out  1     1-cycle pulse: a mask of all zeros was accepted
//  err_multi    out  1     1-cycle pulse: a multi-hot mask was rejected (ONEHOT_CHECK_EN only)
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is asynchronous, active-high, named reset.
//  Reset values: state=IDLE, pending=0, req_ready=1, idx_valid=0, idx_out=0, idx_last=0,
//    sel_idx=0, sel_err=1, err_empty=0, err_multi=0.
//  FSM states: IDLE, DRAIN.
//  - IDLE: req_ready=1, idx_valid=0.
//    - On req_valid with req_mask!=0: pending<=req_mask, go to DRAIN.
//    - On req_valid with req_mask==0: err_empty pulses the next cycle; stay in IDLE.
//  - DRAIN: req_ready=0, idx_valid=1.
//    - idx_out = index of the lowest set bit of pending. This is combinational from the register.
//    - idx_last = (pending has exactly one bit set).
//    - On idx_valid&&idx_ready: clear that bit of pending.
//    - If idx_last was set at the handshake: go to IDLE; req_ready=1 on the following cycle.
//  Latency: accepted mask -> first idx_valid = 1 cycle. Each further index = 1 cycle while idx_ready=1.
//  Backpressure: with idx_ready=0, idx_out and idx_last hold stable and pending is unchanged.
//  req_valid is ignored while in DRAIN, because req_ready=0; the mask is not captured.
//  Throughput: a k-bit mask occupies k+1 cycles minimum, including the return to IDLE.
//  Select path: registered every cycle and independent of the FSM.
//  - sel_in 1..16: sel_idx<=sel_in-1 (5-bit subtract, truncated to 4 bits), sel_err<=0.
//  - sel_in 0 or 17..31: sel_idx<=0, sel_err<=1.
//  Reset asserted mid-DRAIN: pending is cleared immediately; the remaining indices are discarded.
// CONFIGURATION
//  Macro ONEHOT_CHECK_EN.
//  - Defined: in IDLE, a req_mask with more than one bit set is accepted but not captured.
//    err_multi pulses for 1 cycle and the block stays in IDLE. Only one-hot masks are drained,
//    so idx_last is always 1.
//  - Undefined: multi-hot masks are drained lowest-first. err_multi is tied to 0.
// TESTING
//  1 One-hot: req_mask=16'h0008 with req_valid=1 and idx_ready=1.
//    -> next cycle idx_valid=1, idx_out=3, idx_last=1; following cycle idx_valid=0, req_ready=1.
//  2 Multi-hot, macro undefined: req_mask=16'h8421.
//    -> idx_out sequence 0,5,10,15 on consecutive cycles; idx_last only with 15.
//  3 Backpressure: mask 16'h0006 with idx_ready=0 for 3 cycles.
//    -> idx_out=1 is held stable; after idx_ready=1, the block emits 1 then 2 and returns to IDLE.
//  4 Empty mask: req_mask=0 with req_valid=1.
//    -> err_empty=1 for exactly one cycle, idx_valid stays 0, req_ready stays 1.
//  5 Select path: sel_in=5'd1 -> sel_idx=0, sel_err=0; sel_in=5'd16 -> sel_idx=15, sel_err=0;
//    sel_in=0 and sel_in=17 -> sel_err=1. Each result appears one cycle later.
//  6 Reset in DRAIN after one index of 16'h00F0 -> immediately idx_valid=0, req_ready=1.
//    With ONEHOT_CHECK_EN defined, mask 16'h0003 -> err_multi pulses and no index is emitted.

Source files
------------

// File: rtl/reg_index_encoder.sv
// Register write-enable mask to 4-bit index encoder with lowest-first serialisation.
// Build option: define ONEHOT_CHECK_EN to reject multi-hot masks (err_multi) instead of draining them.
module reg_index_encoder #(
    parameter int NREG = 16,
    parameter int IDXW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [NREG-1:0] req_mask,
    input  logic [4:0]      sel_in,
    output logic [IDXW-1:0] sel_idx,
    output logic            sel_err,
    output logic            idx_valid,
    input  logic            idx_ready,
    output logic [IDXW-1:0] idx_out,
    output logic            idx_last,
    output logic            err_empty,
    output logic            err_multi
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic            err_empty_d;

    // Index of the lowest set bit; scanning downwards lets the lowest hit win.
    function automatic logic [IDXW-1:0] lowest_index(input logic [NREG-1:0] m);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IDXW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_multi(input logic [NREG-1:0] m);
        return (m & (m - NREG'(1))) != '0;
    endfunction

    function automatic logic is_onehot(input logic [NREG-1:0] m);
        return (m != '0) && !is_multi(m);
    endfunction

    function automatic logic sel_in_range(input logic [4:0] s);
        return (s >= 5'd1) && (s <= 5'(NREG));
    endfunction

`ifdef ONEHOT_CHECK_EN
    logic err_multi_d;
`endif

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        err_empty_d = 1'b0;
`ifdef ONEHOT_CHECK_EN
        err_multi_d = 1'b0;
`endif
        req_ready   = 1'b0;
        idx_valid   = 1'b0;
        // pending is zero whenever the block is idle, so these read 0 there.
        idx_out     = lowest_index(pending_q);
        idx_last    = is_onehot(pending_q);

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_mask == '0) begin
                        err_empty_d = 1'b1;
                    end
`ifdef ONEHOT_CHECK_EN
                    else if (is_multi(req_mask)) begin
                        err_multi_d = 1'b1;
                    end
`endif
                    else begin
                        pending_d = req_mask;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                idx_valid = 1'b1;
                if (idx_ready) begin
                    // Clearing the lowest set bit retires exactly the index on idx_out.
                    pending_d = pending_q & (pending_q - NREG'(1));
                    if (idx_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            err_empty <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            err_empty <= err_empty_d;
        end
    end

`ifdef ONEHOT_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_multi <= 1'b0;
        end else begin
            err_multi <= err_multi_d;
        end
    end
`else
    assign err_multi = 1'b0;
`endif

    // Select path: free-running register, unrelated to the mask FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_idx <= '0;
            sel_err <= 1'b1;
        end else if (sel_in_range(sel_in)) begin
            sel_idx <= IDXW'(sel_in - 5'd1);
            sel_err <= 1'b0;
        end else begin
            sel_idx <= '0;
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_index_encoder.sv
// Self-checking bench for reg_index_encoder: queue-based reference model plus directed literal checks.
module tb_reg_index_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_mask = '0;
    logic [4:0]  sel_in = '0;
    logic [3:0]  sel_idx;
    logic        sel_err;
    logic        idx_valid;
    logic        idx_ready = 1'b1;
    logic [3:0]  idx_out;
    logic        idx_last;
    logic        err_empty;
    logic        err_multi;

`ifdef ONEHOT_CHECK_EN
    localparam bit ONEHOT = 1'b1;
`else
    localparam bit ONEHOT = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    reg_index_encoder #(.NREG(16), .IDXW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mask  (req_mask),
        .sel_in    (sel_in),
        .sel_idx   (sel_idx),
        .sel_err   (sel_err),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx_out   (idx_out),
        .idx_last  (idx_last),
        .err_empty (err_empty),
        .err_multi (err_multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of indices still owed to the consumer.
    int       q[$];
    bit       m_empty;
    bit       m_multi;
    bit [3:0] m_sel_idx;
    bit       m_sel_err;

    initial begin
        m_empty = 0; m_multi = 0; m_sel_idx = 0; m_sel_err = 1;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
                m_empty = 0; m_multi = 0; m_sel_idx = 0; m_sel_err = 1;
            end else begin
                m_empty = 0;
                m_multi = 0;
                if (q.size() > 0) begin
                    if (idx_ready) void'(q.pop_front());
                end else if (req_valid) begin
                    if (req_mask == 16'h0) m_empty = 1;
                    else if (ONEHOT && $countones(req_mask) > 1) m_multi = 1;
                    else for (int b = 0; b < 16; b++) if (req_mask[b]) q.push_back(b);
                end
                if (sel_in >= 5'd1 && sel_in <= 5'd16) begin
                    m_sel_idx = 4'(sel_in - 5'd1);
                    m_sel_err = 0;
                end else begin
                    m_sel_idx = 0;
                    m_sel_err = 1;
                end
            end
        end
    end

    // Compare process: every falling edge outside reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("m_req_ready", req_ready, q.size() == 0);
                check("m_idx_valid", idx_valid, q.size() > 0);
                check("m_idx_out",   idx_out,   q.size() > 0 ? q[0] : 0);
                check("m_idx_last",  idx_last,  q.size() == 1);
                check("m_err_empty", err_empty, m_empty);
                check("m_err_multi", err_multi, m_multi);
                check("m_sel_idx",   sel_idx,   m_sel_idx);
                check("m_sel_err",   sel_err,   m_sel_err);
            end
        end
    end

    task automatic send(input logic [15:0] m);
        @(negedge clk);
        req_valid = 1'b1;
        req_mask  = m;
        @(negedge clk);
        req_valid = 1'b0;
        req_mask  = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_idx_valid", idx_valid, 0);
        check("rst_idx_out",   idx_out,   0);
        check("rst_idx_last",  idx_last,  0);
        check("rst_sel_idx",   sel_idx,   0);
        check("rst_sel_err",   sel_err,   1);
        check("rst_err_empty", err_empty, 0);
        check("rst_err_multi", err_multi, 0);
        reset = 1'b0;

        // One-hot mask 0x0008 -> index 3.
        idx_ready = 1'b1;
        send(16'h0008);
        check("t1_valid", idx_valid, 1);
        check("t1_out",   idx_out,   3);
        check("t1_last",  idx_last,  1);
        @(negedge clk);
        check("t1_done_valid", idx_valid, 0);
        check("t1_done_ready", req_ready, 1);

`ifndef ONEHOT_CHECK_EN
        // Multi-hot 0x8421 -> 0,5,10,15.
        send(16'h8421);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("t2_valid", idx_valid, 1);
            check("t2_out",   idx_out,   5 * i);
            check("t2_last",  idx_last,  i == 3);
        end
        @(negedge clk);
        check("t2_done_ready", req_ready, 1);

        // Backpressure on 0x0006.
        idx_ready = 1'b0;
        send(16'h0006);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("t3_hold_out",  idx_out,  1);
            check("t3_hold_last", idx_last, 0);
            check("t3_hold_rdy",  req_ready, 0);
        end
        idx_ready = 1'b1;
        @(negedge clk);
        check("t3_out2",  idx_out,  2);
        check("t3_last2", idx_last, 1);
        @(negedge clk);
        check("t3_done_ready", req_ready, 1);
`else
        // Multi-hot rejected.
        send(16'h0003);
        check("t2_err_multi", err_multi, 1);
        check("t2_no_valid",  idx_valid, 0);
        @(negedge clk);
        check("t2_multi_pulse", err_multi, 0);

        idx_ready = 1'b0;
        send(16'h0004);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check("t3_hold_out", idx_out, 2);
            check("t3_hold_vld", idx_valid, 1);
        end
        idx_ready = 1'b1;
        @(negedge clk);
        check("t3_done_ready", req_ready, 1);
`endif

        // Empty mask.
        send(16'h0000);
        check("t4_err_empty", err_empty, 1);
        check("t4_no_valid",  idx_valid, 0);
        check("t4_ready",     req_ready, 1);
        @(negedge clk);
        check("t4_pulse_end", err_empty, 0);

        // Select path.
        sel_in = 5'd1;  @(negedge clk);
        check("t5_sel1_idx", sel_idx, 0);  check("t5_sel1_err", sel_err, 0);
        sel_in = 5'd16; @(negedge clk);
        check("t5_sel16_idx", sel_idx, 15); check("t5_sel16_err", sel_err, 0);
        sel_in = 5'd0;  @(negedge clk);
        check("t5_sel0_err", sel_err, 1);
        sel_in = 5'd17; @(negedge clk);
        check("t5_sel17_err", sel_err, 1); check("t5_sel17_idx", sel_idx, 0);
        sel_in = 5'd7;  @(negedge clk);
        check("t5_sel7_idx", sel_idx, 6);

        // Reset mid-drain.
`ifndef ONEHOT_CHECK_EN
        send(16'h00F0);
        check("t6_first", idx_out, 4);
        @(negedge clk);
        check("t6_second", idx_out, 5);
`else
        send(16'h0010);
        check("t6_first", idx_out, 4);
`endif
        #1 reset = 1'b1;
        #1;
        check("t6_rst_valid", idx_valid, 0);
        check("t6_rst_ready", req_ready, 1);
        check("t6_rst_last",  idx_last,  0);
        @(negedge clk);
        reset = 1'b0;

        // Randomised traffic checked by the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            @(negedge clk);
            req_valid = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r == 0)      req_mask = '0;
            else if (r < 5)  req_mask = 16'(1) << $urandom_range(0, 15);
            else             req_mask = 16'($urandom);
            idx_ready = ($urandom_range(0, 3) != 0);
            sel_in    = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
